// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed BCD display scanner.
// Defaults match a 4-digit panel refreshed from a 100 MHz-class clock.
package bcd_disp_pkg;

    localparam int DIGIT_W          = 4;
    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_REFRESH_DIV  = 100000;
    localparam int DEF_BLANK_CYCLES = 16;

endpackage

// File: rtl/bcd_lz_mask.sv
// Leading-zero blank mask: a digit goes dark when it and every digit
// above it are zero with no decimal point lit. Digit 0 always shows.
module bcd_lz_mask
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
    input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]              dp,
    input  logic                               en,
    output logic [NUM_DIGITS-1:0]              blank
);

    logic run_zero;

    always_comb begin
        run_zero = 1'b1;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run_zero = run_zero & (digits[i] == '0) & ~dp[i];
            blank[i] = en & run_zero;
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD display scanner with frame-synchronous shadow,
// anti-ghost dead time and leading-zero suppression.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]           dp_in,
    input  logic                            lz_blank_en,
    output logic [NUM_DIGITS-1:0]           anode_n,
    output logic [DIGIT_W-1:0]              digit_val,
    output logic                            dp_out,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    logic [CW-1:0]                      cnt;
    logic [IW-1:0]                      idx;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] sh_dig;
    logic [NUM_DIGITS-1:0]              sh_dp;
    logic                               started;
    logic                               fresh;
    logic                               cnt_wrap;
    logic                               frame_wrap;
    logic                               dead;
    logic [NUM_DIGITS-1:0]              blank;

    assign cnt_wrap   = (cnt == CNT_LAST);
    assign frame_wrap = cnt_wrap && (idx == IDX_LAST);

    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign dead = 1'b0;
        end else begin : g_dead
            assign dead = (cnt < CW'(BLANK_CYCLES));
        end
    endgenerate

    bcd_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .digits (sh_dig),
        .dp     (sh_dp),
        .en     (lz_blank_en),
        .blank  (blank)
    );

    // Scan position and shadow; the first enabled cycle only loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            sh_dig  <= '0;
            sh_dp   <= '0;
            started <= 1'b0;
            fresh   <= 1'b0;
        end else if (enable) begin
            if (!started) begin
                started <= 1'b1;
                sh_dig  <= digits_in;
                sh_dp   <= dp_in;
                fresh   <= 1'b1;
            end else begin
                fresh <= frame_wrap;
                if (cnt_wrap) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (frame_wrap) begin
                    sh_dig <= digits_in;
                    sh_dp  <= dp_in;
                end
            end
        end
    end

    // Output stage trails the scan position by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_n     <= '1;
            digit_val   <= '0;
            dp_out      <= 1'b0;
            digit_idx   <= '0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            anode_n     <= '1;
            frame_start <= 1'b0;
        end else begin
            digit_idx   <= idx;
            digit_val   <= sh_dig[idx];
            dp_out      <= sh_dp[idx];
            frame_start <= fresh;
            if (!started || dead || blank[idx])
                anode_n <= '1;
            else
                anode_n <= ~(SEL_ONE << idx);
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner at 4 digits, 8 cycles/slot,
// 2 dead cycles.
module tb_bcd_display_scanner;

    localparam int N = 4;
    localparam int D = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  anode_n;
    logic [3:0]  digit_val;
    logic        dp_out;
    logic [1:0]  digit_idx;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    logic [3:0] cap_an  [33];
    logic [3:0] cap_val [33];
    logic       cap_dp  [33];
    logic [1:0] cap_idx [33];
    logic       cap_fs  [33];

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  p;
        logic        l;
        logic [3:0]  dark;
    } vec_t;

    bcd_display_scanner #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .lz_blank_en (lz_blank_en),
        .anode_n     (anode_n),
        .digit_val   (digit_val),
        .dp_out      (dp_out),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_an(int s, int c, logic dark);
        logic [3:0] one;
        one = 4'b0001;
        return (c < B || dark) ? 4'hF : ~(one << s);
    endfunction

    task automatic do_reset(input logic [15:0] d, input logic [3:0] p,
                            input logic l);
        enable = 1'b0;
        rst_n = 1'b0;
        digits_in = d;
        dp_in = p;
        lz_blank_en = l;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (frame_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic capture(output bit ok);
        wait_fs(ok);
        if (ok) begin
            for (int k = 0; k < 33; k++) begin
                if (k > 0) @(negedge clk);
                cap_an[k]  = anode_n;
                cap_val[k] = digit_val;
                cap_dp[k]  = dp_out;
                cap_idx[k] = digit_idx;
                cap_fs[k]  = frame_start;
            end
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        rst_n = 1'b0;
        digits_in = 16'h4321;
        dp_in = 4'h0;
        lz_blank_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (anode_n !== 4'hF || digit_val !== 4'h0 || dp_out !== 1'b0 ||
            digit_idx !== 2'd0 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: an=%b val=%h dp=%b idx=%0d fs=%b expected 1111 0 0 0 0",
                     anode_n, digit_val, dp_out, digit_idx, frame_start);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b0 || anode_n !== 4'hF) begin
            failures++;
            $display("FAIL first_cycle: fs=%b an=%b expected 0 1111",
                     frame_start, anode_n);
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1 || digit_idx !== 2'd0 || digit_val !== 4'h1) begin
            failures++;
            $display("FAIL first_frame_start: fs=%b idx=%0d val=%h expected 1 0 1",
                     frame_start, digit_idx, digit_val);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (anode_n !== 4'b1110 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL after_dead: an=%b fs=%b expected 1110 0",
                     anode_n, frame_start);
        end
    endtask

    task automatic test_frame_patterns();
        vec_t tab [6];
        bit ok;
        tab[0] = '{d: 16'h4321, p: 4'b0000, l: 1'b0, dark: 4'b0000};
        tab[1] = '{d: 16'h0007, p: 4'b0000, l: 1'b1, dark: 4'b1110};
        tab[2] = '{d: 16'h0007, p: 4'b0100, l: 1'b1, dark: 4'b1000};
        tab[3] = '{d: 16'h0000, p: 4'b0000, l: 1'b1, dark: 4'b1110};
        tab[4] = '{d: 16'h0B00, p: 4'b0000, l: 1'b1, dark: 4'b1000};
        tab[5] = '{d: 16'h0000, p: 4'b0000, l: 1'b0, dark: 4'b0000};
        for (int i = 0; i < 6; i++) begin
            logic [15:0] d;
            logic [3:0]  p;
            logic [3:0]  dk;
            d = tab[i].d;
            p = tab[i].p;
            dk = tab[i].dark;
            do_reset(d, p, tab[i].l);
            capture(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL frame_timeout case%0d: no frame_start", i);
                continue;
            end
            for (int k = 0; k < 32; k++) begin
                int s;
                int c;
                logic [3:0] ea;
                logic [3:0] ev;
                s = k / D;
                c = k % D;
                ea = exp_an(s, c, dk[s]);
                ev = d[4*s +: 4];
                checks++;
                if (cap_an[k] !== ea || cap_val[k] !== ev ||
                    cap_dp[k] !== p[s] || cap_idx[k] !== 2'(s) ||
                    cap_fs[k] !== (k == 0)) begin
                    failures++;
                    $display("FAIL frame case%0d k%0d: an=%b val=%h dp=%b idx=%0d fs=%b expected %b %h %b %0d %b",
                             i, k, cap_an[k], cap_val[k], cap_dp[k],
                             cap_idx[k], cap_fs[k], ea, ev, p[s], s, k == 0);
                end
            end
            checks++;
            if (cap_fs[32] !== 1'b1) begin
                failures++;
                $display("FAIL frame_period case%0d: fs at 32 = %b expected 1",
                         i, cap_fs[32]);
            end
        end
    endtask

    task automatic test_midframe_update();
        bit ok;
        do_reset(16'h1111, 4'h0, 1'b0);
        wait_fs(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midframe_timeout: no frame_start");
            return;
        end
        for (int k = 0; k < 64; k++) begin
            logic [3:0] ev;
            if (k > 0) @(negedge clk);
            ev = (k < 32) ? 4'h1 : 4'h2;
            checks++;
            if (digit_val !== ev || frame_start !== (k == 0 || k == 32)) begin
                failures++;
                $display("FAIL midframe k%0d: val=%h fs=%b expected %h %b",
                         k, digit_val, frame_start, ev, (k == 0 || k == 32));
            end
            if (k == 10) digits_in = 16'h2222;
        end
    endtask

    task automatic test_enable_hold();
        bit ok;
        do_reset(16'h4321, 4'h0, 1'b0);
        wait_fs(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL enable_timeout: no frame_start");
            return;
        end
        repeat (19) @(negedge clk);
        checks++;
        if (anode_n !== 4'b1011 || digit_idx !== 2'd2) begin
            failures++;
            $display("FAIL pre_hold: an=%b idx=%0d expected 1011 2",
                     anode_n, digit_idx);
        end
        enable = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            checks++;
            if (anode_n !== 4'hF || digit_idx !== 2'd2 ||
                digit_val !== 4'h3 || frame_start !== 1'b0) begin
                failures++;
                $display("FAIL hold j%0d: an=%b idx=%0d val=%h fs=%b expected 1111 2 3 0",
                         j, anode_n, digit_idx, digit_val, frame_start);
            end
        end
        enable = 1'b1;
        for (int j = 0; j < 13; j++) begin
            logic [3:0] ea;
            logic [1:0] ei;
            @(negedge clk);
            ea = (j < 4) ? 4'b1011 : (j < 6) ? 4'hF :
                 (j < 12) ? 4'b0111 : 4'hF;
            ei = (j < 4) ? 2'd2 : (j < 12) ? 2'd3 : 2'd0;
            checks++;
            if (anode_n !== ea || digit_idx !== ei ||
                frame_start !== (j == 12)) begin
                failures++;
                $display("FAIL resume j%0d: an=%b idx=%0d fs=%b expected %b %0d %b",
                         j, anode_n, digit_idx, frame_start, ea, ei, j == 12);
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        bit ok;
        int seen;
        do_reset(16'h4321, 4'h0, 1'b0);
        wait_fs(ok);
        repeat (26) @(negedge clk);
        checks++;
        if (!ok || anode_n !== 4'b0111 || digit_val !== 4'h4) begin
            failures++;
            $display("FAIL pre_reset: ok=%b an=%b val=%h expected 1 0111 4",
                     ok, anode_n, digit_val);
        end
        rst_n = 1'b0;
        digits_in = 16'h5678;
        dp_in = 4'b0001;
        #1;
        checks++;
        if (anode_n !== 4'hF || digit_val !== 4'h0 || dp_out !== 1'b0 ||
            digit_idx !== 2'd0 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: an=%b val=%h dp=%b idx=%0d fs=%b expected 1111 0 0 0 0",
                     anode_n, digit_val, dp_out, digit_idx, frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int t = 1; t <= 6 && seen == 0; t++) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = t;
        end
        checks++;
        if (seen != 2 || digit_val !== 4'h8 || dp_out !== 1'b1 ||
            digit_idx !== 2'd0) begin
            failures++;
            $display("FAIL restart: fs_cycle=%0d val=%h dp=%b idx=%0d expected 2 8 1 0",
                     seen, digit_val, dp_out, digit_idx);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (anode_n !== 4'b1110 || digit_val !== 4'h8) begin
            failures++;
            $display("FAIL restart_lit: an=%b val=%h expected 1110 8",
                     anode_n, digit_val);
        end
    endtask

    initial begin
        test_reset();
        test_frame_patterns();
        test_midframe_update();
        test_enable_hold();
        test_reset_mid_slot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
